// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: builds the S-box in an external 256x8 memory, then streams a
// length-prefixed plaintext image into a length-prefixed ciphertext image.
module arc4_encrypt #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata
);

    localparam logic [7:0] KB_LAST = 8'(KEY_BYTES - 1);

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RD_I,
        KSA_GET_I,
        KSA_RD_J,
        KSA_GET_J,
        KSA_WR_I,
        KSA_WR_J,
        LEN_RD,
        LEN_GET,
        LEN_WR,
        PRGA_RD_I,
        PRGA_GET_I,
        PRGA_RD_J,
        PRGA_GET_J,
        PRGA_WR_I,
        PRGA_WR_J,
        PRGA_RD_PAD,
        PRGA_GET_PAD,
        PRGA_WR_CT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [7:0] i_r, i_nx;
    logic [7:0] j_r, j_nx;
    logic [7:0] k_r, k_nx;
    logic [7:0] kb_r, kb_nx;

    logic [7:0]             si_r, si_nx;
    logic [7:0]             sj_r, sj_nx;
    logic [7:0]             len_r, len_nx;
    logic [7:0]             ct_r, ct_nx;
    logic [8*KEY_BYTES-1:0] key_r, key_nx;

    // Byte n of the key, counting from the most significant byte.
    function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] kv,
                                            input logic [7:0]             n);
        logic [8*KEY_BYTES-1:0] sh;
        sh = kv << {n, 3'b000};
        return sh[8*KEY_BYTES-1 -: 8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i_r   <= '0;
            j_r   <= '0;
            k_r   <= '0;
            kb_r  <= '0;
        end else begin
            state <= state_nx;
            i_r   <= i_nx;
            j_r   <= j_nx;
            k_r   <= k_nx;
            kb_r  <= kb_nx;
        end
    end

    // Datapath captures carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        si_r  <= si_nx;
        sj_r  <= sj_nx;
        len_r <= len_nx;
        ct_r  <= ct_nx;
        key_r <= key_nx;
    end

    // Outputs decode state and registers only, never the inputs directly.
    always_comb begin
        state_nx  = state;
        i_nx      = i_r;
        j_nx      = j_r;
        k_nx      = k_r;
        kb_nx     = kb_r;
        si_nx     = si_r;
        sj_nx     = sj_r;
        len_nx    = len_r;
        ct_nx     = ct_r;
        key_nx    = key_r;
        rdy       = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                rdy = 1'b1;
                if (en) begin
                    key_nx   = key;
                    i_nx     = '0;
                    state_nx = INIT;
                end
            end

            INIT: begin
                s_addr   = i_r;
                s_wrdata = i_r;
                s_wren   = 1'b1;
                i_nx     = i_r + 8'd1;
                if (i_r == 8'hFF) begin
                    j_nx     = '0;
                    kb_nx    = '0;
                    state_nx = KSA_RD_I;
                end
            end

            KSA_RD_I: begin
                s_addr   = i_r;
                state_nx = KSA_GET_I;
            end

            KSA_GET_I: begin
                si_nx    = s_rddata;
                j_nx     = j_r + s_rddata + key_byte(key_r, kb_r);
                state_nx = KSA_RD_J;
            end

            KSA_RD_J: begin
                s_addr   = j_r;
                state_nx = KSA_GET_J;
            end

            KSA_GET_J: begin
                sj_nx    = s_rddata;
                state_nx = KSA_WR_I;
            end

            KSA_WR_I: begin
                s_addr   = i_r;
                s_wrdata = sj_r;
                s_wren   = 1'b1;
                state_nx = KSA_WR_J;
            end

            KSA_WR_J: begin
                s_addr   = j_r;
                s_wrdata = si_r;
                s_wren   = 1'b1;
                i_nx     = i_r + 8'd1;
                kb_nx    = (kb_r == KB_LAST) ? 8'd0 : kb_r + 8'd1;
                state_nx = (i_r == 8'hFF) ? LEN_RD : KSA_RD_I;
            end

            LEN_RD: begin
                pt_addr  = '0;
                state_nx = LEN_GET;
            end

            LEN_GET: begin
                len_nx   = pt_rddata;
                state_nx = LEN_WR;
            end

            // i is preloaded with 1: the per-byte pre-increment of i folded in.
            LEN_WR: begin
                ct_addr   = '0;
                ct_wrdata = len_r;
                ct_wren   = 1'b1;
                i_nx      = 8'd1;
                j_nx      = '0;
                k_nx      = 8'd1;
                state_nx  = (len_r == 8'd0) ? DONE : PRGA_RD_I;
            end

            PRGA_RD_I: begin
                s_addr   = i_r;
                state_nx = PRGA_GET_I;
            end

            PRGA_GET_I: begin
                si_nx    = s_rddata;
                j_nx     = j_r + s_rddata;
                state_nx = PRGA_RD_J;
            end

            PRGA_RD_J: begin
                s_addr   = j_r;
                state_nx = PRGA_GET_J;
            end

            PRGA_GET_J: begin
                sj_nx    = s_rddata;
                state_nx = PRGA_WR_I;
            end

            PRGA_WR_I: begin
                s_addr   = i_r;
                s_wrdata = sj_r;
                s_wren   = 1'b1;
                state_nx = PRGA_WR_J;
            end

            PRGA_WR_J: begin
                s_addr   = j_r;
                s_wrdata = si_r;
                s_wren   = 1'b1;
                state_nx = PRGA_RD_PAD;
            end

            PRGA_RD_PAD: begin
                s_addr   = si_r + sj_r;
                pt_addr  = k_r;
                state_nx = PRGA_GET_PAD;
            end

            PRGA_GET_PAD: begin
                ct_nx    = pt_rddata ^ s_rddata;
                state_nx = PRGA_WR_CT;
            end

            // Termination is tested before k advances, so len 255 never wraps k.
            PRGA_WR_CT: begin
                ct_addr   = k_r;
                ct_wrdata = ct_r;
                ct_wren   = 1'b1;
                if (k_r == len_r) begin
                    state_nx = DONE;
                end else begin
                    k_nx     = k_r + 8'd1;
                    i_nx     = i_r + 8'd1;
                    state_nx = PRGA_RD_I;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule
